difficulty_manager: RTL and testbench
=====================================

# difficulty_manager

Registered, parametrised difficulty-level selector for the game controller. Takes debounced push-button levels, detects rising edges, and holds the last selected level until a new press changes it; the level does not fall back to a default on release. Supports direct (one key per level) and step (up/down keys) modes, and a lock input that freezes selection while a round is in progress. Sits between the key debouncers and the game FSM / speed-control logic.

## Interface
Parameters:
- NUM_LEVELS, 3, number of selectable levels (2..16); level 0 = easiest
- LEVEL_W, 4, width of difficulty output; must satisfy 2^LEVEL_W >= NUM_LEVELS
- DEFAULT_LEVEL, 0, level loaded at reset; must be < NUM_LEVELS
- MODE, 0, 0 = direct, 1 = step
- WRAP, 0, step mode only: 1 = wrap at ends, 0 = saturate

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  NUM_LEVELS  debounced key levels, active-high. Direct mode: key_in[i] selects level i. Step mode: key_in[0] = down, key_in[1] = up, other bits ignored
- lock  in  1  high while a round runs; selection frozen
- difficulty  out  LEVEL_W  current level, registered
- level_changed  out  1  one-cycle pulse when difficulty takes a new, different value
- locked  out  1  registered copy of lock state

## Operation
- Edge detect: key_q <= key_in every cycle; rise = key_in & ~key_q.
- FSM states: SELECT, LOCKED. SELECT -> LOCKED when lock=1. LOCKED -> SELECT when lock=0. locked = (state == LOCKED).
- Selection is evaluated only when lock=0, using the lock input directly, not the state. An edge arriving in the same cycle lock rises is discarded.
- Direct mode: if any rise bit is set, difficulty <= index of the lowest set rise bit, so the easiest level wins on simultaneous presses.
- Step mode:
  - up-rise alone: difficulty+1.
  - down-rise alone: difficulty-1.
  - Both in the same cycle: no change.
  - At NUM_LEVELS-1, up wraps to 0 when WRAP=1, else holds.
  - At 0, down wraps to NUM_LEVELS-1 when WRAP=1, else holds.
- level_changed = 1 for exactly the cycle in which difficulty is first seen at its new value, and only if the value differs from the old one. Re-pressing the current level or saturating produces no pulse.
- Edges occurring while locked are dropped, not queued. key_q keeps tracking during lock, so a key held across unlock does not fire; a fresh press is required.
- Arithmetic is done in LEVEL_W bits; results are never >= NUM_LEVELS.

## Timing
- Reset (asynchronous assert, synchronous release):
  - difficulty = DEFAULT_LEVEL, level_changed = 0, locked = 0, state = SELECT.
  - key_q = all ones, so keys held through reset do not fire on release.
- Latency: key_in rises before edge k -> difficulty and level_changed update at edge k, i.e. visible one cycle after the key is first sampled high.
- lock high before edge k -> locked = 1 after edge k. Any rise sampled at edge k is ignored.
- Reset asserted mid-operation: all outputs return to reset values immediately; no pulse is generated.
- Maximum one level change per cycle; no combinational path from inputs to outputs.

## Structure
- Shared package difficulty_pkg:
  - LVL_EASY=0, LVL_MEDIUM=1, LVL_HARD=2
  - MODE_DIRECT=0, MODE_STEP=1
  - state enum {SELECT, LOCKED}
- One sub-module: key_edge_detect, parametrised WIDTH, with clk/rst_n, reset value all ones, output rise[WIDTH-1:0]. Reused by other key consumers.
- Parameter legality (NUM_LEVELS, DEFAULT_LEVEL, LEVEL_W) is checked with elaboration-time assertions.

## Test plan
- Reset/default: NUM_LEVELS=3, DEFAULT_LEVEL=1. Release rst_n with key_in=3'b100 held -> difficulty=1, no level_changed, and no change until key[2] is released and pressed again.
- Direct select: press key[2] -> difficulty=2 next cycle with a 1-cycle level_changed. Release -> stays 2. Press key[2] again -> no pulse.
- Simultaneous press: key_in 000 -> 110 in one cycle -> difficulty=1 (lowest index wins).
- Lock: lock=1, then press key[0] -> difficulty unchanged, locked=1. Hold key[0], drop lock -> unchanged. Release and repress -> difficulty=0.
- Step mode (MODE=1, NUM_LEVELS=3, WRAP=0): from 0, three up presses -> 1, 2, 2 with pulses only on the first two. Up and down in the same cycle -> no change. With WRAP=1: from 2, up -> 0; from 0, down -> 2.
- Async reset mid-sequence: rst_n low between clock edges while difficulty=2 -> difficulty=DEFAULT_LEVEL immediately, level_changed=0.

Source files
------------

// File: rtl/difficulty_pkg.sv
// Shared constants and types for the difficulty selector and its helpers.
// Level and mode encodings are shared with the game FSM and speed control.
package difficulty_pkg;

    localparam int LVL_EASY   = 0;
    localparam int LVL_MEDIUM = 1;
    localparam int LVL_HARD   = 2;

    localparam int MODE_DIRECT = 0;
    localparam int MODE_STEP   = 1;

    localparam int MIN_LEVELS = 2;
    localparam int MAX_LEVELS = 16;

    typedef enum logic {
        SELECT = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for debounced key levels. The history register resets
// to all ones so keys already held when reset releases never report a press.
module key_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] key_d;

    always_comb begin
        key_d = key_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '1;
        end else begin
            key_q <= key_d;
        end
    end

    assign rise = key_in & ~key_q;

endmodule

// File: rtl/difficulty_manager.sv
// Difficulty-level selector: turns key presses into a held, registered level,
// in direct (one key per level) or step (down/up keys) mode, frozen while locked.
module difficulty_manager
    import difficulty_pkg::*;
#(
    parameter int NUM_LEVELS    = 3,
    parameter int LEVEL_W       = 4,
    parameter int DEFAULT_LEVEL = 0,
    parameter int MODE          = 0,
    parameter int WRAP          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LEVELS-1:0] key_in,
    input  logic                  lock,
    output logic [LEVEL_W-1:0]    difficulty,
    output logic                  level_changed,
    output logic                  locked
);

    localparam logic [LEVEL_W-1:0] TOP_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LEVEL_W-1:0] RESET_LEVEL = LEVEL_W'(DEFAULT_LEVEL);

    generate
        if (NUM_LEVELS < MIN_LEVELS || NUM_LEVELS > MAX_LEVELS) begin : g_bad_num_levels
            $error("difficulty_manager: NUM_LEVELS must be in 2..16");
        end
        if ((1 << LEVEL_W) < NUM_LEVELS) begin : g_bad_level_w
            $error("difficulty_manager: LEVEL_W too narrow for NUM_LEVELS");
        end
        if (DEFAULT_LEVEL < 0 || DEFAULT_LEVEL >= NUM_LEVELS) begin : g_bad_default
            $error("difficulty_manager: DEFAULT_LEVEL must be below NUM_LEVELS");
        end
        if (MODE != MODE_DIRECT && MODE != MODE_STEP) begin : g_bad_mode
            $error("difficulty_manager: MODE must be 0 (direct) or 1 (step)");
        end
    endgenerate

    logic [NUM_LEVELS-1:0] rise;

    key_edge_detect #(
        .WIDTH(NUM_LEVELS)
    ) u_key_edge_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .key_in(key_in),
        .rise  (rise)
    );

    state_t             state_q;
    state_t             state_d;
    logic [LEVEL_W-1:0] difficulty_q;
    logic [LEVEL_W-1:0] difficulty_d;
    logic               level_changed_q;
    logic               level_changed_d;

    logic [LEVEL_W-1:0] direct_next;
    logic [LEVEL_W-1:0] step_next;
    logic               up_rise;
    logic               down_rise;

    assign up_rise   = rise[1];
    assign down_rise = rise[0];

    // Scan from the top down so the lowest pressed index is the one kept.
    always_comb begin
        direct_next = difficulty_q;
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                direct_next = LEVEL_W'(i);
            end
        end
    end

    always_comb begin
        step_next = difficulty_q;
        if (up_rise && !down_rise) begin
            if (difficulty_q == TOP_LEVEL) begin
                step_next = (WRAP != 0) ? '0 : difficulty_q;
            end else begin
                step_next = difficulty_q + LEVEL_W'(1);
            end
        end else if (down_rise && !up_rise) begin
            if (difficulty_q == '0) begin
                step_next = (WRAP != 0) ? TOP_LEVEL : difficulty_q;
            end else begin
                step_next = difficulty_q - LEVEL_W'(1);
            end
        end
    end

    // Selection looks at the raw lock input, so a press landing on the same
    // edge that lock rises is discarded rather than applied one cycle late.
    always_comb begin
        state_d         = state_q;
        difficulty_d    = difficulty_q;
        level_changed_d = 1'b0;

        case (state_q)
            SELECT:  if (lock)  state_d = LOCKED;
            LOCKED:  if (!lock) state_d = SELECT;
            default: state_d = SELECT;
        endcase

        if (!lock) begin
            if (MODE == MODE_STEP) begin
                difficulty_d = step_next;
            end else begin
                difficulty_d = direct_next;
            end
        end

        level_changed_d = (difficulty_d != difficulty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= SELECT;
            difficulty_q    <= RESET_LEVEL;
            level_changed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            difficulty_q    <= difficulty_d;
            level_changed_q <= level_changed_d;
        end
    end

    assign difficulty    = difficulty_q;
    assign level_changed = level_changed_q;
    assign locked        = (state_q == LOCKED);

endmodule

// File: tb/tb_difficulty_manager.sv
// Bench for difficulty_manager: three instances (direct, step/saturate,
// step/wrap) checked each cycle against a level-based reference model.
module tb_difficulty_manager;

    logic             clk;
    logic             rst_n;
    logic [2:0][2:0]  key_v;
    logic [2:0]       lock_v;
    logic [2:0][3:0]  diff_v;
    logic [2:0]       chg_v;
    logic [2:0]       lck_v;

    int n_vec;
    int n_err;

    // Per-instance configuration: 0 = direct (default 1), 1 = step saturate, 2 = step wrap.
    localparam int N_LVL = 3;
    int p_mode [3] = '{0, 1, 1};
    int p_wrap [3] = '{0, 0, 1};
    int p_def  [3] = '{1, 0, 0};

    int         m_lvl  [3];
    logic [2:0] m_prev [3];
    logic       m_chg  [3];
    logic       m_lck  [3];

    logic [5:0] exp_q [$];

    difficulty_manager #(.NUM_LEVELS(3), .LEVEL_W(4), .DEFAULT_LEVEL(1), .MODE(0), .WRAP(0)) u_dir (
        .clk(clk), .rst_n(rst_n), .key_in(key_v[0]), .lock(lock_v[0]),
        .difficulty(diff_v[0]), .level_changed(chg_v[0]), .locked(lck_v[0])
    );

    difficulty_manager #(.NUM_LEVELS(3), .LEVEL_W(4), .DEFAULT_LEVEL(0), .MODE(1), .WRAP(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .key_in(key_v[1]), .lock(lock_v[1]),
        .difficulty(diff_v[1]), .level_changed(chg_v[1]), .locked(lck_v[1])
    );

    difficulty_manager #(.NUM_LEVELS(3), .LEVEL_W(4), .DEFAULT_LEVEL(0), .MODE(1), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .key_in(key_v[2]), .lock(lock_v[2]),
        .difficulty(diff_v[2]), .level_changed(chg_v[2]), .locked(lck_v[2])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_lvl[k]  = p_def[k];
            m_prev[k] = 3'b111;
            m_chg[k]  = 1'b0;
            m_lck[k]  = 1'b0;
        end
    endfunction

    function automatic void model_edge(int k);
        logic [2:0] pressed;
        int         nxt;
        pressed = key_v[k] & ~m_prev[k];
        nxt     = m_lvl[k];
        if (!lock_v[k] && pressed != 3'b000) begin
            if (p_mode[k] == 0) begin
                for (int i = 2; i >= 0; i--) if (pressed[i]) nxt = i;
            end else if (pressed[1] && !pressed[0]) begin
                if (p_wrap[k] != 0) nxt = (m_lvl[k] + 1) % N_LVL;
                else                nxt = (m_lvl[k] + 1 > N_LVL - 1) ? N_LVL - 1 : m_lvl[k] + 1;
            end else if (pressed[0] && !pressed[1]) begin
                if (p_wrap[k] != 0) nxt = (m_lvl[k] + N_LVL - 1) % N_LVL;
                else                nxt = (m_lvl[k] == 0) ? 0 : m_lvl[k] - 1;
            end
        end
        m_chg[k]  = (nxt != m_lvl[k]);
        m_lvl[k]  = nxt;
        m_prev[k] = key_v[k];
        m_lck[k]  = lock_v[k];
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int k = 0; k < 3; k++) model_edge(k);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        key_v  = '0;
        key_v[0] = 3'b100;
        lock_v = '0;
        model_reset();
        tick();
        tick();
        n_vec++;
        if (diff_v[0] !== 4'd1 || chg_v[0] !== 1'b0 || lck_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_default: diff=%0d chg=%b lck=%b, expected diff=1 chg=0 lck=0",
                     diff_v[0], chg_v[0], lck_v[0]);
        end
        #4 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) key_v[0] = 3'b000;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (diff_v[k] !== 4'(m_lvl[k]) || chg_v[k] !== m_chg[k] || lck_v[k] !== m_lck[k]) begin
                    n_err++;
                    $display("FAIL reset_release[%0d]: diff=%0d chg=%b lck=%b, expected diff=%0d chg=%b lck=%b",
                             k, diff_v[k], chg_v[k], lck_v[k], m_lvl[k], m_chg[k], m_lck[k]);
                end
            end
        end
        n_vec++;
        if (diff_v[0] !== 4'd1) begin
            n_err++;
            $display("FAIL reset_held_key: diff=%0d, expected 1", diff_v[0]);
        end
    endtask

    task automatic test_direct_select();
        logic [2:0] stim [4] = '{3'b100, 3'b000, 3'b100, 3'b000};
        logic       pulse[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int s = 0; s < 4; s++) begin
            key_v[0] = stim[s];
            tick();
            n_vec++;
            if (diff_v[0] !== 4'd2 || chg_v[0] !== pulse[s] || diff_v[0] !== 4'(m_lvl[0])) begin
                n_err++;
                $display("FAIL direct_select step %0d: diff=%0d chg=%b, expected diff=2 chg=%b",
                         s, diff_v[0], chg_v[0], pulse[s]);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_v[0] = 3'b110;
        tick();
        n_vec++;
        if (diff_v[0] !== 4'd1 || chg_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL simultaneous: diff=%0d chg=%b, expected diff=1 chg=1", diff_v[0], chg_v[0]);
        end
        key_v[0] = 3'b000;
        tick();
        n_vec++;
        if (diff_v[0] !== 4'd1 || chg_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL simultaneous_release: diff=%0d chg=%b, expected diff=1 chg=0", diff_v[0], chg_v[0]);
        end
    endtask

    task automatic test_lock();
        // Columns: lock, key, expected diff, expected locked, expected pulse.
        logic       l_in [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0] k_in [6] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
        int         e_d  [6] = '{1, 1, 1, 1, 0, 0};
        logic       e_l  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       e_c  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 6; s++) begin
            lock_v[0] = l_in[s];
            key_v[0]  = k_in[s];
            tick();
            n_vec++;
            if (diff_v[0] !== 4'(e_d[s]) || lck_v[0] !== e_l[s] || chg_v[0] !== e_c[s]) begin
                n_err++;
                $display("FAIL lock step %0d: diff=%0d lck=%b chg=%b, expected diff=%0d lck=%b chg=%b",
                         s, diff_v[0], lck_v[0], chg_v[0], e_d[s], e_l[s], e_c[s]);
            end
        end
    endtask

    task automatic test_step();
        int   e_sat [3] = '{1, 2, 2};
        logic p_sat [3] = '{1'b1, 1'b1, 1'b0};
        for (int s = 0; s < 3; s++) begin
            key_v[1] = 3'b010;
            tick();
            n_vec++;
            if (diff_v[1] !== 4'(e_sat[s]) || chg_v[1] !== p_sat[s]) begin
                n_err++;
                $display("FAIL step_up_sat %0d: diff=%0d chg=%b, expected diff=%0d chg=%b",
                         s, diff_v[1], chg_v[1], e_sat[s], p_sat[s]);
            end
            key_v[1] = 3'b000;
            tick();
        end
        key_v[1] = 3'b011;
        tick();
        n_vec++;
        if (diff_v[1] !== 4'd2 || chg_v[1] !== 1'b0) begin
            n_err++;
            $display("FAIL step_both: diff=%0d chg=%b, expected diff=2 chg=0", diff_v[1], chg_v[1]);
        end
        key_v[1] = 3'b000;
        key_v[2] = 3'b001;
        tick();
        n_vec++;
        if (diff_v[2] !== 4'd2 || chg_v[2] !== 1'b1) begin
            n_err++;
            $display("FAIL step_wrap_down: diff=%0d chg=%b, expected diff=2 chg=1", diff_v[2], chg_v[2]);
        end
        key_v[2] = 3'b000;
        tick();
        key_v[2] = 3'b010;
        tick();
        n_vec++;
        if (diff_v[2] !== 4'd0 || chg_v[2] !== 1'b1) begin
            n_err++;
            $display("FAIL step_wrap_up: diff=%0d chg=%b, expected diff=0 chg=1", diff_v[2], chg_v[2]);
        end
        key_v[2] = 3'b000;
        tick();
    endtask

    task automatic test_random();
        logic [5:0] exp_v;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 2) == 0) key_v[k] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) lock_v[k] = ~lock_v[k];
            end
            tick();
            for (int k = 0; k < 3; k++) exp_q.push_back({4'(m_lvl[k]), m_chg[k], m_lck[k]});
            for (int k = 0; k < 3; k++) begin
                exp_v = exp_q.pop_front();
                n_vec++;
                if ({diff_v[k], chg_v[k], lck_v[k]} !== exp_v) begin
                    n_err++;
                    $display("FAIL random c%0d[%0d]: diff=%0d chg=%b lck=%b, expected diff=%0d chg=%b lck=%b",
                             c, k, diff_v[k], chg_v[k], lck_v[k], exp_v[5:2], exp_v[1], exp_v[0]);
                end
            end
        end
        key_v  = '0;
        lock_v = '0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        key_v[0] = 3'b001;
        tick();
        key_v[0] = 3'b100;
        tick();
        key_v[0] = 3'b000;
        tick();
        n_vec++;
        if (diff_v[0] !== 4'd2) begin
            n_err++;
            $display("FAIL async_setup: diff=%0d, expected 2", diff_v[0]);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (diff_v[k] !== 4'(p_def[k]) || chg_v[k] !== 1'b0 || lck_v[k] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset[%0d]: diff=%0d chg=%b lck=%b, expected diff=%0d chg=0 lck=0",
                         k, diff_v[k], chg_v[k], lck_v[k], p_def[k]);
            end
        end
        tick();
        #4 rst_n = 1'b1;
        tick();
        n_vec++;
        if (diff_v[0] !== 4'd1 || chg_v[0] !== 1'b0) begin
            n_err++;
            $display("FAIL async_release: diff=%0d chg=%b, expected diff=1 chg=0", diff_v[0], chg_v[0]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_direct_select();
        test_simultaneous();
        test_lock();
        test_step();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
